// File: rtl/sync_pkg.sv
// Shared helpers for pointer/flag synchronisers: gray arithmetic, step checking, parameter limits.
package sync_pkg;

    localparam int unsigned STAGES_MIN = 2;
    localparam int unsigned STAGES_MAX = 4;
    localparam int unsigned FILTER_MAX = 15;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned PTR_MAX_W  = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    // Zero-extended operands are safe: leading zeros do not disturb the lower bits.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic gray_step_err(input ptr_t cur, input ptr_t prev);
        return $countones(cur ^ prev) > 1;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-stage flop chain with a per-bit synchronous reset value.
module sync_chain #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] rstval_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= rstval_i;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/pntr_flag_sync_multi.sv
// Synchronises a foreign-domain gray FIFO pointer and status flags; adds binary pointer,
// multi-bit-step detection, per-flag glitch filtering and edge pulses.
module pntr_flag_sync_multi
    import sync_pkg::*;
#(
    parameter int unsigned AWIDTH = 3,
    parameter int unsigned STAGES = 2,
    parameter int unsigned FLAGS  = 1,
    parameter int unsigned FILTER = 0
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic [AWIDTH:0]     pntr_gray_i,
    input  logic [FLAGS-1:0]    flag_i,
    input  logic [FLAGS-1:0]    resetval_i,
    output logic [AWIDTH:0]     pntr_gray_o,
    output logic [AWIDTH:0]     pntr_bin_o,
    output logic                pntr_err_o,
    output logic                pntr_err_sticky_o,
    output logic [FLAGS-1:0]    flag_o,
    output logic [FLAGS-1:0]    flag_rise_o,
    output logic [FLAGS-1:0]    flag_fall_o
);

    localparam int unsigned AWVAL = AWIDTH + 1;
    localparam logic [AWVAL-1:0] PTR_RST = '0;

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("pntr_flag_sync_multi: STAGES must be 2..4");
    end
    if (FILTER > FILTER_MAX) begin : g_bad_filter
        $error("pntr_flag_sync_multi: FILTER must be 0..15");
    end
    if (FLAGS < 1 || AWVAL > PTR_MAX_W) begin : g_bad_width
        $error("pntr_flag_sync_multi: bad FLAGS or AWIDTH");
    end

    logic [AWVAL-1:0] gray_sync;
    logic [FLAGS-1:0] flag_sync;

    sync_chain #(.WIDTH(AWVAL), .STAGES(STAGES)) u_ptr_chain (
        .clk_i    (clk_i),
        .srst_i   (srst_i),
        .d_i      (pntr_gray_i),
        .rstval_i (PTR_RST),
        .q_o      (gray_sync)
    );

    sync_chain #(.WIDTH(FLAGS), .STAGES(STAGES)) u_flag_chain (
        .clk_i    (clk_i),
        .srst_i   (srst_i),
        .d_i      (flag_i),
        .rstval_i (resetval_i),
        .q_o      (flag_sync)
    );

    assign pntr_gray_o = gray_sync;

    // Pointer post-processing: binary conversion and step check share one cycle of latency.
    logic [AWVAL-1:0] prev_q, bin_q;
    logic             err_q, sticky_q;
    logic             err_d;

    assign err_d = gray_step_err(PTR_MAX_W'(gray_sync), PTR_MAX_W'(prev_q));

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            prev_q   <= '0;
            bin_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            prev_q   <= gray_sync;
            bin_q    <= AWVAL'(gray2bin(PTR_MAX_W'(gray_sync)));
            err_q    <= err_d;
            sticky_q <= sticky_q | err_d;
        end
    end

    assign pntr_bin_o        = bin_q;
    assign pntr_err_o        = err_q;
    assign pntr_err_sticky_o = sticky_q;

    // Flag filter: a new level must persist FILTER+1 synced cycles before flag_o follows.
    logic [FLAGS-1:0] flag_q, flag_d, rise_q, rise_d, fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [FLAGS];
    logic [CNT_W-1:0] cnt_d [FLAGS];

    always_comb begin
        flag_d = flag_q;
        rise_d = '0;
        fall_d = '0;
        for (int n = 0; n < FLAGS; n++) begin
            cnt_d[n] = '0;
            if (flag_sync[n] != flag_q[n]) begin
                if (cnt_q[n] == CNT_W'(FILTER)) begin
                    flag_d[n] = flag_sync[n];
                    rise_d[n] = flag_sync[n];
                    fall_d[n] = ~flag_sync[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            flag_q <= resetval_i;
            rise_q <= '0;
            fall_q <= '0;
            for (int n = 0; n < FLAGS; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            flag_q <= flag_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int n = 0; n < FLAGS; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign flag_o      = flag_q;
    assign flag_rise_o = rise_q;
    assign flag_fall_o = fall_q;

endmodule

// File: tb/tb_pntr_flag_sync_multi.sv
// Scoreboarded directed bench: stimulus queues cycle-tagged expectations, a negedge monitor checks them.
module tb_pntr_flag_sync_multi;

    localparam int unsigned AW = 3;
    localparam int unsigned AV = AW + 1;
    localparam int unsigned ST = 3;
    localparam int unsigned FL = 2;
    localparam int unsigned FI = 2;

    typedef enum int {F_GRAY, F_BIN, F_ERR, F_STICKY, F_FLAG, F_RISE, F_FALL} fld_e;
    typedef struct {
        int         cyc;
        fld_e       fld;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic          clk = 1'b0;
    logic          srst;
    logic [AV-1:0] gray_i;
    logic [FL-1:0] flag_i, resetval;
    logic [AV-1:0] gray_o, bin_o;
    logic          err_o, sticky_o;
    logic [FL-1:0] flag_o, rise_o, fall_o;
    logic [7:0]    mon_act;

    pntr_flag_sync_multi #(.AWIDTH(AW), .STAGES(ST), .FLAGS(FL), .FILTER(FI)) dut (
        .clk_i             (clk),
        .srst_i            (srst),
        .pntr_gray_i       (gray_i),
        .flag_i            (flag_i),
        .resetval_i        (resetval),
        .pntr_gray_o       (gray_o),
        .pntr_bin_o        (bin_o),
        .pntr_err_o        (err_o),
        .pntr_err_sticky_o (sticky_o),
        .flag_o            (flag_o),
        .flag_rise_o       (rise_o),
        .flag_fall_o       (fall_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input fld_e f);
        case (f)
            F_GRAY:   return 8'(gray_o);
            F_BIN:    return 8'(bin_o);
            F_ERR:    return 8'(err_o);
            F_STICKY: return 8'(sticky_o);
            F_FLAG:   return 8'(flag_o);
            F_RISE:   return 8'(rise_o);
            default:  return 8'(fall_o);
        endcase
    endfunction

    function automatic logic [3:0] to_gray(input int i);
        logic [3:0] b;
        b = 4'(i);
        return b ^ (b >> 1);
    endfunction

    task automatic exp_at(input int dly, input fld_e f, input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + dly;
        e.fld = f;
        e.exp = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every expectation due in the current cycle, independent of stimulus.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                checks++;
                mon_act = actual(sb[i].fld);
                if (sb[i].cyc < cyc || mon_act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s at cycle %0d: got %0h expected %0h (due %0d)",
                             sb[i].name, cyc, mon_act, sb[i].exp, sb[i].cyc);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        srst = 1'b1; resetval = 2'b11; flag_i = 2'b11; gray_i = '0;
        tick(3);
        exp_at(0, F_GRAY, 8'h0, "rst_gray");
        exp_at(0, F_BIN, 8'h0, "rst_bin");
        exp_at(0, F_ERR, 8'h0, "rst_err");
        exp_at(0, F_STICKY, 8'h0, "rst_sticky");
        exp_at(0, F_FLAG, 8'h3, "rst_flag");
        exp_at(0, F_RISE, 8'h0, "rst_rise");
        exp_at(0, F_FALL, 8'h0, "rst_fall");
        srst = 1'b0;
        exp_at(8, F_FLAG, 8'h3, "post_rst_flag");
        exp_at(8, F_FALL, 8'h0, "post_rst_fall");
        tick(8);

        srst = 1'b1; resetval = 2'b00; flag_i = 2'b00;
        exp_at(1, F_FLAG, 8'h0, "rst0_flag");
        tick(1);
        srst = 1'b0;

        // Latency of a single gray step.
        gray_i = 4'b0001;
        exp_at(2, F_GRAY, 8'h0, "lat_gray_early");
        exp_at(3, F_GRAY, 8'h1, "lat_gray");
        exp_at(3, F_BIN, 8'h0, "lat_bin_early");
        exp_at(4, F_BIN, 8'h1, "lat_bin");
        exp_at(4, F_ERR, 8'h0, "lat_err");
        tick(1);

        // Walk the full gray sequence and wrap back to zero.
        for (int i = 2; i <= 16; i++) begin
            gray_i = to_gray(i % 16);
            exp_at(3, F_GRAY, 8'(to_gray(i % 16)), "wrap_gray");
            exp_at(4, F_BIN, 8'(i % 16), "wrap_bin");
            exp_at(4, F_ERR, 8'h0, "wrap_err");
            tick(1);
        end
        tick(6);
        exp_at(0, F_STICKY, 8'h0, "wrap_sticky");
        tick(1);

        // Two-bit jump.
        gray_i = 4'b0011;
        exp_at(3, F_ERR, 8'h0, "bad_err_early");
        exp_at(4, F_ERR, 8'h1, "bad_err");
        exp_at(4, F_BIN, 8'h2, "bad_bin");
        exp_at(5, F_ERR, 8'h0, "bad_err_end");
        exp_at(5, F_STICKY, 8'h1, "bad_sticky");
        exp_at(10, F_STICKY, 8'h1, "bad_sticky_hold");
        tick(11);

        // Glitch of FILTER synced cycles is swallowed.
        flag_i = 2'b01;
        exp_at(6, F_FLAG, 8'h0, "glitch_flag");
        exp_at(7, F_FLAG, 8'h0, "glitch_flag2");
        exp_at(6, F_RISE, 8'h0, "glitch_rise");
        tick(2);
        flag_i = 2'b00;
        tick(8);

        // FILTER+1 cycles passes, then the return to low passes too.
        flag_i = 2'b01;
        exp_at(5, F_FLAG, 8'h0, "pass_flag_early");
        exp_at(6, F_FLAG, 8'h1, "pass_flag");
        exp_at(6, F_RISE, 8'h1, "pass_rise");
        exp_at(7, F_RISE, 8'h0, "pass_rise_end");
        exp_at(8, F_FALL, 8'h0, "pass_fall_early");
        exp_at(9, F_FLAG, 8'h0, "pass_flag_low");
        exp_at(9, F_FALL, 8'h1, "pass_fall");
        exp_at(10, F_FALL, 8'h0, "pass_fall_end");
        tick(3);
        flag_i = 2'b00;
        tick(10);

        // Both channels together.
        flag_i = 2'b11;
        exp_at(5, F_FLAG, 8'h0, "both_flag_early");
        exp_at(6, F_FLAG, 8'h3, "both_flag");
        exp_at(6, F_RISE, 8'h3, "both_rise");
        exp_at(7, F_RISE, 8'h0, "both_rise_end");
        tick(8);

        // Reset while a fall is about to be accepted.
        flag_i = 2'b00;
        tick(5);
        srst = 1'b1; resetval = 2'b11;
        exp_at(1, F_GRAY, 8'h0, "mid_gray");
        exp_at(1, F_BIN, 8'h0, "mid_bin");
        exp_at(1, F_ERR, 8'h0, "mid_err");
        exp_at(1, F_STICKY, 8'h0, "mid_sticky");
        exp_at(1, F_FLAG, 8'h3, "mid_flag");
        exp_at(1, F_RISE, 8'h0, "mid_rise");
        exp_at(1, F_FALL, 8'h0, "mid_fall");
        tick(1);
        srst = 1'b0;
        exp_at(2, F_GRAY, 8'h0, "after_gray_early");
        exp_at(3, F_GRAY, 8'h3, "after_gray");
        exp_at(4, F_ERR, 8'h1, "after_err_vs_zero");
        exp_at(4, F_BIN, 8'h2, "after_bin");
        exp_at(5, F_STICKY, 8'h1, "after_sticky");
        exp_at(5, F_FLAG, 8'h3, "after_flag_hold");
        exp_at(6, F_FLAG, 8'h0, "after_flag_fall");
        exp_at(6, F_FALL, 8'h3, "after_fall");
        tick(7);

        for (int w = 0; w < 50 && sb.size() != 0; w++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations never checked, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
